issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Buffered, clocked successor to the combinational fetch/decode stage.
- Accepts raw instructions with their PC into a parametrised FIFO and decodes the head entry.
- Tracks register hazards with an internal scoreboard and holds issue while a control transfer is unresolved.
- Issues one decoded instruction per cycle to execute over a valid/ready handshake; sits between instruction memory and the execute/writeback pipeline.

Parameters:
- XLEN, 32, instruction/PC/immediate width.
- DEPTH, 4, FIFO entries; power of two, >=2.
- NREG, 32, architectural registers; 32 only in this generation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_inst.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  FIFO can accept.
- out_valid  out  1  head decoded and hazard-free.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  PC of head.
- rd, rs1, rs2  out  5 each  register fields.
- funct3  out  3  funct3 field.
- imm  out  XLEN  sign-extended immediate.
- alu_op  out  3  0 pass imm, 1 PC+4 link, 5 op-imm, 6 reg-reg.
- addr_alu_op  out  2  1 PC+imm, 2 rs1+imm memory, 3 rs1+imm JALR.
- wb_op  out  2  0 none, 1 ALU, 2 address unit.
- jmp_op  out  2  0 none, 1 unconditional, 2 branch.
- mem_op  out  2  0 none, 1 load, 2 store.
- fault  out  1  head opcode illegal.
- wb_valid  in  1  writeback occurring.
- wb_rd  in  5  register written back.
- jmp_resolve  in  1  outstanding jump/branch resolved.
- flush  in  1  discard queued instructions.
- busy_reg  out  32  scoreboard; bit 0 always 0.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset values: FIFO empty, count=0, busy_reg=0, jmp_pending=0, out_valid=0, in_ready=1. Decoded outputs are don't-care while out_valid=0.
- Enqueue: occurs when in_valid && in_ready. in_ready = (count<DEPTH) && !flush; there is no full-with-pop bypass.
- Enqueue latency: minimum 1 cycle from enqueue to out_valid; there is no input-to-output bypass. Pointers wrap modulo DEPTH.
- Decode: combinational on the head entry. LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP are legal.
- Illegal opcode (including all-zero): fault=1, all ops=0, and the entry still issues. It does not touch the scoreboard or jmp_pending.
- Source-register use:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- Effective busy view: eff_busy = busy_reg & ~(wb_valid ? onehot(wb_rd) : 0). Writeback therefore bypasses into the hazard check in the same cycle.
- Hazard: any used source register nonzero and eff_busy; or wb_op!=0, rd!=0 and eff_busy[rd] (WAW); or jmp_pending.
- out_valid = !empty && !hazard && !flush.
- Issue occurs when out_valid && out_ready. On issue:
  - pop the head;
  - if wb_op!=0 and rd!=0, set busy[rd] next cycle;
  - if jmp_op!=0, set jmp_pending.
- Set and clear of the same bit in the same cycle: the set wins. x0 is never marked busy.
- jmp_resolve clears jmp_pending. If it coincides with issue of a new jump, jmp_pending stays set.
- flush: empties the FIFO next cycle and clears jmp_pending. The scoreboard is retained, because in-flight ops still write back. An enqueue presented in the flush cycle is dropped.
- Once valid is asserted, out_valid stays high until issue or flush. Outputs are stable while out_ready is low.
- Reset asserted mid-operation returns all state to reset values immediately; this is asynchronous.

Decomposition:
- Shared package holds:
  - opcode constants;
  - alu_op, addr_alu_op, wb_op, jmp_op and mem_op encodings;
  - a decoded-instruction struct.
- One natural sub-module, inst_decode: purely combinational decode of a single instruction, instantiated on the FIFO head.
- FIFO storage and the scoreboard stay in the top level.

Test Plan:
- Reset, then enqueue addi x3,x2,1 at pc 0x100 -> out_valid rises the next cycle with rd=3, rs1=2, imm=1, alu_op=5, wb_op=1; after issue busy_reg=0x8.
- Issue add x3,x1,x2, then enqueue add x4,x3,x3 -> out_valid=0 until wb_valid with wb_rd=3, when out_valid=1 in that same cycle.
- Enqueue bne x1,x2,-4 then addi -> bne issues (jmp_op=2, imm=0xFFFFFFFC) and addi stalls until jmp_resolve pulses, then issues the following cycle.
- Fill DEPTH=4 with out_ready=0 -> count=4 and in_ready=0; one issue -> count=3 and in_ready=1. Fill and drain 8 entries to exercise pointer wrap.
- Enqueue inst=0 -> out_valid=1, fault=1, busy_reg unchanged.
- With 3 entries queued and jmp_pending=1, assert flush together with in_valid -> next cycle count=0, jmp_pending=0, busy_reg unchanged, and the flush-cycle input is dropped.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: RV32 opcodes, micro-op encodings
// and the decoded-instruction record produced by the head decoder.
package issue_queue_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      ALU_PASS   = 3'd0,
      ALU_LINK   = 3'd1,
      ALU_OP_IMM = 3'd5,
      ALU_REG    = 3'd6
   } alu_op_e;

   typedef enum logic [1:0] {
      ADDR_NONE   = 2'd0,
      ADDR_PC_IMM = 2'd1,
      ADDR_MEM    = 2'd2,
      ADDR_JALR   = 2'd3
   } addr_alu_op_e;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_ADDR = 2'd2
   } wb_op_e;

   typedef enum logic [1:0] {
      JMP_NONE   = 2'd0,
      JMP_UNCOND = 2'd1,
      JMP_BRANCH = 2'd2
   } jmp_op_e;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_e;

   typedef struct packed {
      logic [4:0]   rd;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [2:0]   funct3;
      alu_op_e      alu_op;
      addr_alu_op_e addr_alu_op;
      wb_op_e       wb_op;
      jmp_op_e      jmp_op;
      mem_op_e      mem_op;
      logic         use_rs1;
      logic         use_rs2;
      logic         fault;
   } decoded_t;

endpackage

// File: rtl/issue_queue_inst_decode.sv
// Purely combinational decode of one RV32 instruction into micro-op fields,
// source-register usage flags and a sign-extended immediate.
module issue_queue_inst_decode
   import issue_queue_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output decoded_t        dec,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_raw;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      dec.rd     = inst[11:7];
      dec.rs1    = inst[19:15];
      dec.rs2    = inst[24:20];
      dec.funct3 = inst[14:12];
      imm_raw    = '0;
      case (inst[6:0])
         OPC_LUI: begin
            dec.alu_op = ALU_PASS;
            dec.wb_op  = WB_ALU;
            imm_raw    = imm_u;
         end
         OPC_AUIPC: begin
            dec.addr_alu_op = ADDR_PC_IMM;
            dec.wb_op       = WB_ADDR;
            imm_raw         = imm_u;
         end
         OPC_JAL: begin
            dec.alu_op      = ALU_LINK;
            dec.addr_alu_op = ADDR_PC_IMM;
            dec.wb_op       = WB_ALU;
            dec.jmp_op      = JMP_UNCOND;
            imm_raw         = imm_j;
         end
         OPC_JALR: begin
            dec.alu_op      = ALU_LINK;
            dec.addr_alu_op = ADDR_JALR;
            dec.wb_op       = WB_ALU;
            dec.jmp_op      = JMP_UNCOND;
            dec.use_rs1     = 1'b1;
            imm_raw         = imm_i;
         end
         // Target from the address unit; the ALU compares rs1 against rs2.
         OPC_BRANCH: begin
            dec.alu_op      = ALU_REG;
            dec.addr_alu_op = ADDR_PC_IMM;
            dec.jmp_op      = JMP_BRANCH;
            dec.use_rs1     = 1'b1;
            dec.use_rs2     = 1'b1;
            imm_raw         = imm_b;
         end
         OPC_LOAD: begin
            dec.addr_alu_op = ADDR_MEM;
            dec.wb_op       = WB_ADDR;
            dec.mem_op      = MEM_LOAD;
            dec.use_rs1     = 1'b1;
            imm_raw         = imm_i;
         end
         OPC_STORE: begin
            dec.addr_alu_op = ADDR_MEM;
            dec.mem_op      = MEM_STORE;
            dec.use_rs1     = 1'b1;
            dec.use_rs2     = 1'b1;
            imm_raw         = imm_s;
         end
         OPC_OP_IMM: begin
            dec.alu_op  = ALU_OP_IMM;
            dec.wb_op   = WB_ALU;
            dec.use_rs1 = 1'b1;
            imm_raw     = imm_i;
         end
         OPC_OP: begin
            dec.alu_op  = ALU_REG;
            dec.wb_op   = WB_ALU;
            dec.use_rs1 = 1'b1;
            dec.use_rs2 = 1'b1;
         end
         default: dec.fault = 1'b1;
      endcase
   end

   assign imm = XLEN'($signed(imm_raw));

endmodule

// File: rtl/issue_queue.sv
// Buffered fetch/decode stage: FIFO of raw instructions, head decode,
// register scoreboard and jump hold, issuing over a valid/ready handshake.
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int NREG  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                in_inst,
   input  logic [XLEN-1:0]            in_pc,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [4:0]                 rd,
   output logic [4:0]                 rs1,
   output logic [4:0]                 rs2,
   output logic [2:0]                 funct3,
   output logic [XLEN-1:0]            imm,
   output logic [2:0]                 alu_op,
   output logic [1:0]                 addr_alu_op,
   output logic [1:0]                 wb_op,
   output logic [1:0]                 jmp_op,
   output logic [1:0]                 mem_op,
   output logic                       fault,
   input  logic                       wb_valid,
   input  logic [4:0]                 wb_rd,
   input  logic                       jmp_resolve,
   input  logic                       flush,
   output logic [NREG-1:0]            busy_reg,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [31:0]      inst_mem [DEPTH];
   logic [XLEN-1:0]  pc_mem   [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [NREG-1:0]  busy_bits_reg, busy_next, eff_busy, wb_clr, busy_set;
   logic             jmp_pending_reg, jmp_pending_next;

   decoded_t dec;
   logic     empty, enq, issue, writes_rd, src_hazard, waw_hazard, hazard;

   assign empty    = (count_reg == '0);
   assign in_ready = (count_reg < CNT_W'(DEPTH)) && !flush;
   assign enq      = in_valid && in_ready;

   issue_queue_inst_decode #(.XLEN(XLEN)) u_inst_decode (
      .inst (inst_mem[rd_ptr_reg]),
      .dec  (dec),
      .imm  (imm)
   );

   assign writes_rd = (dec.wb_op != WB_NONE) && (dec.rd != 5'd0);

   // Writeback clears a bit in the same cycle it is seen, so it also unblocks the head now.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
         assign wb_clr[gi]   = wb_valid && (wb_rd == 5'(gi));
         assign busy_set[gi] = issue && writes_rd && (dec.rd == 5'(gi));
      end
   endgenerate

   assign eff_busy  = busy_bits_reg & ~wb_clr;
   assign busy_next = ((busy_bits_reg & ~wb_clr) | busy_set) & ~NREG'(1);

   assign src_hazard = (dec.use_rs1 && (dec.rs1 != 5'd0) && eff_busy[dec.rs1]) ||
                       (dec.use_rs2 && (dec.rs2 != 5'd0) && eff_busy[dec.rs2]);
   assign waw_hazard = writes_rd && eff_busy[dec.rd];
   assign hazard     = src_hazard || waw_hazard || jmp_pending_reg;

   assign out_valid = !empty && !hazard && !flush;
   assign issue     = out_valid && out_ready;

   // A jump issuing in the resolve cycle keeps the hold asserted.
   always_comb begin
      jmp_pending_next = jmp_pending_reg;
      if (flush || jmp_resolve) jmp_pending_next = 1'b0;
      if (issue && (dec.jmp_op != JMP_NONE)) jmp_pending_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         busy_bits_reg   <= '0;
         jmp_pending_reg <= 1'b0;
      end else begin
         busy_bits_reg   <= busy_next;
         jmp_pending_reg <= jmp_pending_next;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (enq)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({enq, issue})
               2'b10:   count_reg <= count_reg + CNT_W'(1);
               2'b01:   count_reg <= count_reg - CNT_W'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         inst_mem[wr_ptr_reg] <= in_inst;
         pc_mem[wr_ptr_reg]   <= in_pc;
      end
   end

   assign out_pc      = pc_mem[rd_ptr_reg];
   assign rd          = dec.rd;
   assign rs1         = dec.rs1;
   assign rs2         = dec.rs2;
   assign funct3      = dec.funct3;
   assign alu_op      = dec.alu_op;
   assign addr_alu_op = dec.addr_alu_op;
   assign wb_op       = dec.wb_op;
   assign jmp_op      = dec.jmp_op;
   assign mem_op      = dec.mem_op;
   assign fault       = dec.fault;
   assign busy_reg    = busy_bits_reg;
   assign count       = count_reg;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_issue_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_inst = '0, in_pc = '0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] out_pc, imm, busy_reg;
   logic [4:0]  rd, rs1, rs2, wb_rd = '0;
   logic [2:0]  funct3, alu_op;
   logic [1:0]  addr_alu_op, wb_op, jmp_op, mem_op;
   logic        fault, wb_valid = 1'b0, jmp_resolve = 1'b0, flush = 1'b0;
   logic [2:0]  count;

   always #5 clk = ~clk;

   issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_inst(in_inst), .in_pc(in_pc),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .imm(imm), .alu_op(alu_op), .addr_alu_op(addr_alu_op),
      .wb_op(wb_op), .jmp_op(jmp_op), .mem_op(mem_op), .fault(fault),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .jmp_resolve(jmp_resolve),
      .flush(flush), .busy_reg(busy_reg), .count(count)
   );

   localparam logic [31:0] ADDI_X3 = 32'h0011_0193;  // addi x3,x2,1
   localparam logic [31:0] ADD_X3  = 32'h0020_81B3;  // add  x3,x1,x2
   localparam logic [31:0] ADD_X4  = 32'h0031_8233;  // add  x4,x3,x3
   localparam logic [31:0] BNE_M4  = 32'hFE20_9EE3;  // bne  x1,x2,-4
   localparam logic [31:0] ADDI_X5 = 32'h0070_0293;  // addi x5,x0,7
   localparam logic [31:0] ADDI_X6 = 32'h0000_0313;  // addi x6,x0,0
   localparam logic [31:0] ADDI_X7 = 32'h0000_0393;  // addi x7,x0,0
   localparam logic [31:0] JAL_X0  = 32'h0080_006F;  // jal  x0,8

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] inst, pc, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      bit          imm_care, alu_care, fault, use1, use2;
      int          alu, addr, wb, jmp, mem;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_busy = '0;
   bit          m_jpend = 1'b0;

   // Expected issue record derived from the RV32 formats with plain arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      int   i_imm, s_imm, b_imm, j_imm;
      i_imm = $signed(inst[31:20]);
      s_imm = $signed({inst[31:25], inst[11:7]});
      b_imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2;
      j_imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2;
      e.inst = inst; e.pc = pc; e.rd = inst[11:7]; e.rs1 = inst[19:15];
      e.rs2 = inst[24:20]; e.f3 = inst[14:12]; e.imm = '0;
      e.imm_care = 1; e.alu_care = 1; e.fault = 0; e.use1 = 0; e.use2 = 0;
      e.alu = 0; e.addr = 0; e.wb = 0; e.jmp = 0; e.mem = 0;
      case (inst[6:0])
         7'h37: begin e.imm = inst & 32'hFFFF_F000; e.wb = 1; end
         7'h17: begin e.imm = inst & 32'hFFFF_F000; e.addr = 1; e.wb = 2; e.alu_care = 0; end
         7'h6F: begin e.imm = 32'(j_imm); e.alu = 1; e.addr = 1; e.wb = 1; e.jmp = 1; end
         7'h67: begin e.imm = 32'(i_imm); e.alu = 1; e.addr = 3; e.wb = 1; e.jmp = 1; e.use1 = 1; end
         7'h63: begin e.imm = 32'(b_imm); e.addr = 1; e.jmp = 2; e.use1 = 1; e.use2 = 1; e.alu_care = 0; end
         7'h03: begin e.imm = 32'(i_imm); e.addr = 2; e.wb = 2; e.mem = 1; e.use1 = 1; e.alu_care = 0; end
         7'h23: begin e.imm = 32'(s_imm); e.addr = 2; e.mem = 2; e.use1 = 1; e.use2 = 1; e.alu_care = 0; end
         7'h13: begin e.imm = 32'(i_imm); e.alu = 5; e.wb = 1; e.use1 = 1; end
         7'h33: begin e.alu = 6; e.wb = 1; e.use1 = 1; e.use2 = 1; e.imm_care = 0; end
         default: begin e.fault = 1; e.imm_care = 0; end
      endcase
      return e;
   endfunction

   // Monitor: compares DUT against the model every cycle and pops on each issue.
   exp_t        h;
   logic [31:0] m_clr, m_eff, m_nb;
   bit          m_ev, m_en, m_iss;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         sb_q.delete(); m_busy = '0; m_jpend = 1'b0;
      end else begin
         m_clr = wb_valid ? (32'd1 << wb_rd) : 32'd0;
         m_eff = m_busy & ~m_clr;
         m_ev  = 1'b0;
         if (sb_q.size() > 0) begin
            h = sb_q[0];
            m_ev = !flush && !m_jpend &&
                   !(h.use1 && h.rs1 != 0 && m_eff[h.rs1]) &&
                   !(h.use2 && h.rs2 != 0 && m_eff[h.rs2]) &&
                   !(h.wb != 0 && h.rd != 0 && m_eff[h.rd]);
         end
         m_en = in_valid && (sb_q.size() < DEPTH) && !flush;
         chk("out_valid", out_valid, m_ev);
         chk("in_ready", in_ready, (sb_q.size() < DEPTH) && !flush);
         chk("count", count, sb_q.size());
         chk("busy_reg", busy_reg, m_busy);
         m_nb  = m_busy & ~m_clr;
         m_iss = out_valid && out_ready && (sb_q.size() > 0);
         if (flush || jmp_resolve) m_jpend = 1'b0;
         if (m_iss) begin
            h = sb_q.pop_front();
            $display("issue pc=%08h inst=%08h rd=%0d rs1=%0d rs2=%0d fault=%0d", h.pc, h.inst, h.rd, h.rs1, h.rs2, h.fault);
            chk("pc", out_pc, h.pc);
            chk("rd", rd, h.rd);
            chk("rs1", rs1, h.rs1);
            chk("rs2", rs2, h.rs2);
            chk("funct3", funct3, h.f3);
            chk("fault", fault, h.fault);
            chk("addr_alu_op", addr_alu_op, h.addr);
            chk("wb_op", wb_op, h.wb);
            chk("jmp_op", jmp_op, h.jmp);
            chk("mem_op", mem_op, h.mem);
            if (h.imm_care) chk("imm", imm, h.imm);
            if (h.alu_care) chk("alu_op", alu_op, h.alu);
            if (h.wb != 0 && h.rd != 0) m_nb[h.rd] = 1'b1;
            if (h.jmp != 0) m_jpend = 1'b1;
         end
         m_busy = m_nb;
         if (flush) sb_q.delete();
         else if (m_en) sb_q.push_back(ref_decode(in_inst, in_pc));
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; wb_valid = 1'b0; jmp_resolve = 1'b0; flush = 1'b0;
   endtask

   task automatic put(input logic [31:0] i, input logic [31:0] p);
      idle(); in_valid = 1'b1; in_inst = i; in_pc = p;
   endtask

   task automatic wb(input logic [4:0] r);
      idle(); wb_valid = 1'b1; wb_rd = r;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] op;
      case ($urandom_range(0, 11))
         0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
         4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7, 8: op = 7'h13;
         9: op = 7'h33;  10: op = 7'($urandom_range(0, 127));
         default: return 32'd0;
      endcase
      return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              3'($urandom), 5'($urandom_range(0, 7)), op};
   endfunction

   function automatic logic [4:0] pick_busy();
      for (int t = 0; t < 8; t++) begin
         int r = $urandom_range(1, 7);
         if (m_busy[r]) return 5'(r);
      end
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      logic [31:0] pc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy_reg, 0);
      cyc(); rst_n = 1'b1;

      // addi: one-cycle latency then busy x3 after issue
      put(ADDI_X3, 32'h100); out_ready = 1'b1;
      @(negedge clk); chk("no_bypass", out_valid, 0); cyc();
      idle();
      @(negedge clk);
      chk("addi_valid", out_valid, 1); chk("addi_rd", rd, 3); chk("addi_rs1", rs1, 2);
      chk("addi_imm", imm, 1); chk("addi_alu", alu_op, 5); chk("addi_wb", wb_op, 1);
      cyc();
      wb(5'd3); @(negedge clk); chk("addi_busy", busy_reg, 32'h8); cyc();

      // RAW stall released by same-cycle writeback
      put(ADD_X3, 32'h104); cyc();
      put(ADD_X4, 32'h108); @(negedge clk); chk("add1_valid", out_valid, 1); cyc();
      idle(); @(negedge clk); chk("raw_stall0", out_valid, 0); cyc();
      @(negedge clk); chk("raw_stall1", out_valid, 0); cyc();
      wb(5'd3); @(negedge clk); chk("wb_bypass", out_valid, 1); cyc();
      wb(5'd4); @(negedge clk); chk("add2_busy", busy_reg, 32'h10); cyc();

      // branch hold until resolve
      put(BNE_M4, 32'h200); cyc();
      put(ADDI_X5, 32'h204); @(negedge clk);
      chk("bne_valid", out_valid, 1); chk("bne_jmp", jmp_op, 2); chk("bne_imm", imm, 32'hFFFF_FFFC);
      cyc();
      idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); chk("jmp_hold", out_valid, 0); cyc();
      end
      jmp_resolve = 1'b1; @(negedge clk); chk("resolve_cycle", out_valid, 0); cyc();
      idle(); @(negedge clk); chk("after_resolve", out_valid, 1); cyc();
      wb(5'd5); cyc();

      // fill to DEPTH, then one issue, then wrap pointers
      idle(); out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin put(32'h13 | (k << 20), 32'h300 + 4 * k); cyc(); end
      put(32'h0FF0_0013, 32'h310);
      @(negedge clk); chk("full_count", count, 4); chk("full_in_ready", in_ready, 0); cyc();
      idle(); out_ready = 1'b1; @(negedge clk); chk("full_drop", count, 4); cyc();
      out_ready = 1'b0; @(negedge clk); chk("pop_count", count, 3); chk("pop_in_ready", in_ready, 1); cyc();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin put(32'h13 | (k << 20), 32'h400 + 4 * k); cyc(); end
      idle(); repeat (6) cyc();

      // illegal all-zero instruction still issues
      put(32'h0, 32'h500); cyc();
      idle(); @(negedge clk); chk("ill_valid", out_valid, 1); chk("ill_fault", fault, 1); cyc();
      @(negedge clk); chk("ill_busy", busy_reg, 0); cyc();

      // flush with jump pending and three queued entries
      put(ADDI_X6, 32'h600); cyc();
      put(JAL_X0, 32'h604); cyc();
      idle(); cyc();
      for (int k = 0; k < 3; k++) begin put(32'h13, 32'h608 + 4 * k); cyc(); end
      put(ADDI_X7, 32'h700); flush = 1'b1;
      @(negedge clk); chk("pre_flush_count", count, 3); chk("flush_in_ready", in_ready, 0); cyc();
      idle(); @(negedge clk); chk("flush_count", count, 0); chk("flush_busy", busy_reg, 32'h40); cyc();
      put(32'h13, 32'h800); cyc();
      idle(); @(negedge clk); chk("flush_clears_jmp", out_valid, 1); cyc();
      wb(5'd6); cyc();

      // random traffic
      pc = 32'h1000;
      for (int k = 0; k < 3000; k++) begin
         in_valid    = ($urandom_range(0, 1) == 1);
         in_inst     = rand_inst();
         in_pc       = pc;
         if (in_valid) pc += 4;
         out_ready   = ($urandom_range(0, 3) != 0);
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_rd       = pick_busy();
         jmp_resolve = m_jpend && ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 59) == 0);
         cyc();
      end

      // asynchronous reset mid-operation
      idle(); out_ready = 1'b0; put(32'h13, 32'h2000); cyc();
      idle(); cyc();
      rst_n = 1'b0; #1;
      chk("async_count", count, 0);
      chk("async_out_valid", out_valid, 0);
      chk("async_busy", busy_reg, 0);
      chk("async_in_ready", in_ready, 1);
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
